// File: rtl/mul_final_adder.sv
// Final carry-propagate stage of the pipelined 64x64 multiplier.
// Adds the Wallace-tree carry-save pair in two halves across two register
// stages, selects the op-specific 64-bit result, and hands it downstream
// through a valid/ready handshake. At most two transactions are in flight.
module mul_final_adder #(
  parameter int TW   = 132,
  parameter int HW   = 66,
  parameter int XLEN = 64
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [1:0]      in_op,
  input  logic [TW-1:0]   re_op1,
  input  logic [TW-1:0]   re_op2,
  input  logic            op2_1,
  input  logic            addr_cin,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] result
);

  typedef enum logic [1:0] {
    OP_MUL  = 2'b00,
    OP_MULH = 2'b01,
    OP_MULW = 2'b10,
    OP_RSV  = 2'b11
  } op_e;

  // S1 state: low half sum, its carry-out, and the untouched high operands
  logic             r_s1_valid;
  logic [HW-1:0]    r_lo;
  logic             r_c1;
  logic [TW-HW-1:0] r_op1_hi;
  logic [TW-HW-1:0] r_op2_hi;
  op_e              r_op;

  logic             w_accept;
  logic             w_adv2;
  logic [HW:0]      w_lo;
  logic [TW-HW-1:0] w_hi;
  logic [TW-1:0]    w_product;
  logic [XLEN-1:0]  w_sel;
  logic             w_unused;

  assign w_adv2   = r_s1_valid & (~out_valid | out_ready);
  assign in_ready = ~rst & ~flush & (~r_s1_valid | w_adv2);
  assign w_accept = in_valid & in_ready;

  // Carry vector is shifted left by one: op2_1 fills bit 0, re_op2[TW-1] drops out
  assign w_lo = {1'b0, re_op1[HW-1:0]}
              + {1'b0, re_op2[HW-2:0], op2_1}
              + (HW+1)'(addr_cin);

  assign w_hi      = r_op1_hi + r_op2_hi + (TW-HW)'(r_c1);
  assign w_product = {w_hi, r_lo};

  // Instruction-specific slice of the full product
  always_comb begin
    w_sel = w_product[XLEN-1:0];
    case (r_op)
      OP_MULH: w_sel = w_product[2*XLEN-1:XLEN];
      OP_MULW: w_sel = {{(XLEN-32){w_product[31]}}, w_product[31:0]};
      default: w_sel = w_product[XLEN-1:0];
    endcase
  end

  // Bits of the sum/carry pair that never reach the result
  assign w_unused = ^{re_op2[TW-1], w_product[TW-1:2*XLEN]};

  // S1: capture low-half sum and high operands on accept
  always_ff @(posedge clk) begin
    if (rst) begin
      r_s1_valid <= 1'b0;
      r_lo       <= '0;
      r_c1       <= 1'b0;
      r_op1_hi   <= '0;
      r_op2_hi   <= '0;
      r_op       <= OP_MUL;
    end else if (flush) begin
      r_s1_valid <= 1'b0;
    end else if (w_accept) begin
      r_s1_valid <= 1'b1;
      r_lo       <= w_lo[HW-1:0];
      r_c1       <= w_lo[HW];
      r_op1_hi   <= re_op1[TW-1:HW];
      r_op2_hi   <= re_op2[TW-2:HW-1];
      r_op       <= op_e'(in_op);
    end else if (w_adv2) begin
      r_s1_valid <= 1'b0;
    end
  end

  // S2: output register, loads only when S1 advances, holds under back-pressure
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      result    <= '0;
    end else if (flush) begin
      out_valid <= 1'b0;
    end else if (w_adv2) begin
      out_valid <= 1'b1;
      result    <= w_sel;
    end else if (out_valid & out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_mul_final_adder.sv
// Self-checking bench for mul_final_adder: directed corner cases followed by
// randomized traffic, all compared against a queue-based reference model.
module tb_mul_final_adder;

  logic         clk;
  logic         rst;
  logic         flush;
  logic         in_valid;
  logic         in_ready;
  logic [1:0]   in_op;
  logic [131:0] re_op1;
  logic [131:0] re_op2;
  logic         op2_1;
  logic         addr_cin;
  logic         out_valid;
  logic         out_ready;
  logic [63:0]  result;

  mul_final_adder #(.TW(132), .HW(66), .XLEN(64)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op),
    .re_op1(re_op1), .re_op2(re_op2), .op2_1(op2_1), .addr_cin(addr_cin),
    .out_valid(out_valid), .out_ready(out_ready), .result(result)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [63:0] res;
    int          acc;
  } exp_t;

  exp_t q[$];
  int   n_checks = 0;
  int   n_errors = 0;
  int   cur      = 0;
  bit   armed    = 0;
  bit   post_rst = 0;
  bit   last_acc = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got=0x%0h expected=0x%0h (cycle %0d)", tag, got, exp, cur);
    end
  endtask

  // Whole product as one wide sum, then pick the op's bits
  function automatic logic [63:0] ref_res(input logic [1:0] op, input logic [131:0] a,
                                          input logic [131:0] b, input logic b0, input logic cin);
    logic [131:0] p;
    p = a + {b[130:0], b0} + 132'(cin);
    case (op)
      2'b01:   return p[127:64];
      2'b10:   return {{32{p[31]}}, p[31:0]};
      default: return p[63:0];
    endcase
  endfunction

  function automatic logic [131:0] rnd132();
    logic [159:0] r;
    r = {$urandom(), $urandom(), $urandom(), $urandom(), $urandom()};
    return r[131:0];
  endfunction

  // Called at negedge with inputs already driven; checks, updates model, advances one cycle
  task automatic tick();
    bit exp_ov;
    bit exp_ir;
    #3;
    exp_ov = (q.size() > 0) && (cur >= q[0].acc + 2);
    exp_ir = !rst && !flush && ((q.size() < 2) || out_ready);
    last_acc = in_valid && exp_ir;
    if (armed) begin
      if (post_rst) begin
        chk("reset_result", result, 64'h0);
        post_rst = 0;
      end
      chk("out_valid", {63'b0, out_valid}, {63'b0, exp_ov});
      chk("in_ready", {63'b0, in_ready}, {63'b0, exp_ir});
      if (exp_ov) chk("result", result, q[0].res);
    end
    if (exp_ov && out_ready) void'(q.pop_front());
    if (rst || flush) q.delete();
    else if (last_acc) q.push_back('{res: ref_res(in_op, re_op1, re_op2, op2_1, addr_cin), acc: cur});
    if (rst) begin
      armed = 1;
      post_rst = 1;
    end
    @(posedge clk);
    cur++;
    @(negedge clk);
  endtask

  task automatic set_in(input logic [1:0] op, input logic [131:0] a, input logic [131:0] b,
                        input logic b0, input logic cin);
    in_op = op; re_op1 = a; re_op2 = b; op2_1 = b0; addr_cin = cin;
  endtask

  task automatic send(input logic [1:0] op, input logic [131:0] a, input logic [131:0] b,
                      input logic b0, input logic cin);
    set_in(op, a, b, b0, cin);
    in_valid = 1'b1;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (last_acc) break;
    end
    if (!last_acc) chk("send_timeout", 64'd0, 64'd1);
    in_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  initial begin
    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    set_in(2'b00, '0, '0, 1'b0, 1'b0);
    @(negedge clk);
    idle(2);
    rst = 1'b0;
    idle(1);

    // basic sum: 6 + (3<<1|1) + 1 = 14
    send(2'b00, 132'd6, 132'd3, 1'b1, 1'b1);
    idle(3);

    // carry ripples across the half split
    send(2'b01, {66'd0, {66{1'b1}}}, '0, 1'b0, 1'b1);
    idle(3);

    // MULW sign extension, direct and via carry-vector addition
    send(2'b10, 132'h8000_0000, '0, 1'b0, 1'b0);
    send(2'b10, 132'h7FFF_FFFD, 132'd1, 1'b1, 1'b0);
    idle(3);

    // back-pressure: two accepted, third held until the consumer drains
    out_ready = 1'b0;
    send(2'b00, 132'd1, '0, 1'b0, 1'b0);
    send(2'b00, 132'd2, '0, 1'b0, 1'b0);
    set_in(2'b00, 132'd3, '0, 1'b0, 1'b0);
    in_valid = 1'b1;
    idle(3);
    out_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      if (last_acc) break;
    end
    if (!last_acc) chk("bp_accept_timeout", 64'd0, 64'd1);
    in_valid = 1'b0;
    idle(4);

    // flush with both stages full and a new offer in the same cycle
    out_ready = 1'b0;
    send(2'b00, 132'd11, '0, 1'b0, 1'b0);
    send(2'b01, rnd132(), rnd132(), 1'b1, 1'b1);
    set_in(2'b00, 132'd99, '0, 1'b0, 1'b0);
    flush = 1'b1; in_valid = 1'b1;
    tick();
    flush = 1'b0; in_valid = 1'b0;
    idle(1);
    out_ready = 1'b1;
    idle(3);

    // reset with two in flight, then a fresh op
    out_ready = 1'b0;
    send(2'b00, 132'd5, '0, 1'b0, 1'b0);
    send(2'b00, 132'd7, '0, 1'b0, 1'b0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    idle(1);
    out_ready = 1'b1;
    send(2'b00, 132'd40, 132'd1, 1'b0, 1'b1);
    idle(3);

    // randomized traffic with occasional flush and boundary operands
    for (int i = 0; i < 400; i++) begin
      logic [131:0] a;
      logic [131:0] b;
      case ($urandom_range(0, 7))
        0:       begin a = '1; b = '1; end
        1:       begin a = '1; b = '0; end
        default: begin a = rnd132(); b = rnd132(); end
      endcase
      set_in(2'($urandom_range(0, 3)), a, b, 1'($urandom()), 1'($urandom()));
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 2) != 0);
      flush     = ($urandom_range(0, 31) == 0);
      tick();
    end
    flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      if (q.size() == 0) break;
      tick();
    end
    chk("drain_left", 64'(q.size()), 64'd0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/mul_final_adder.md
Name: mul_final_adder

Overview:
- Terminal stage of the pipelined 64x64 multiplier.
- Consumes the carry-save pair produced by the Wallace compression stage:
  - two 132-bit vectors;
  - the carry bit that fills bit 0 of the shifted carry vector;
  - the adder carry-in.
- Performs the final carry-propagate addition as a 2-stage split adder (low 66 bits, then high 66 bits).
- Selects the instruction-specific 64-bit result and presents it to the execute/writeback stage through a valid/ready handshake.

Parameters:
- TW, 132, carry-save vector width (tree width).
- HW, 66, width of low adder half. The high half is TW-HW.
- XLEN, 64, result width.

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- flush  in  1  pipeline kill, synchronous, active-high
- in_valid  in  1  carry-save pair valid
- in_ready  out  1  stage can accept
- in_op  in  2  00 MUL (low), 01 MULH (high), 10 MULW (word, sign-extended), 11 reserved = MUL
- re_op1  in  TW  sum vector
- re_op2  in  TW  carry vector
- op2_1  in  1  bit 0 of the shifted carry vector
- addr_cin  in  1  adder carry-in
- out_valid  out  1  result valid
- out_ready  in  1  consumer accepts
- result  out  XLEN  selected product bits

Behaviour:
- Arithmetic:
  - product[TW-1:0] = re_op1 + {re_op2[TW-2:0], op2_1} + addr_cin, modulo 2^TW.
  - re_op2[TW-1] is discarded.
- Stage S1, on accept (in_valid & in_ready):
  - lo = re_op1[HW-1:0] + {re_op2[HW-2:0], op2_1} + addr_cin, HW+1 bits.
  - Register: lo[HW-1:0]; carry c1 = lo[HW]; re_op1[TW-1:HW]; re_op2[TW-2:HW-1]; in_op.
  - Set s1_valid.
- Stage S2 (output register), when S1 advances:
  - hi = op1_hi + op2_hi + c1 (TW-HW bits).
  - product = {hi, lo}.
  - result:
    - MUL/11: product[63:0]
    - MULH: product[127:64]
    - MULW: {32{product[31]}, product[31:0]}
  - Set out_valid.
- Advance rules:
  - adv2 = s1_valid & (~out_valid | out_ready).
  - out_valid clears on (out_valid & out_ready & ~adv2).
  - in_ready = ~rst & ~flush & (~s1_valid | adv2). This is combinational, with no dependence on in_valid.
- Hold: while out_valid & ~out_ready, result and out_valid are stable. S1 also holds, so at most 2 transactions are in flight.
- Latency: accept at edge N gives out_valid high after edge N+1 (two register stages). Throughput is 1 per cycle with out_ready high.
- Ordering is strictly FIFO; there is no reordering or dropping except on flush/reset.
- Flush:
  - At the next edge, s1_valid and out_valid are both cleared.
  - in_valid in the flush cycle is ignored.
  - A transaction handshaking out in the same cycle as flush still counts as delivered.
- Reset:
  - out_valid = 0, result = 0, s1_valid = 0, and all S1 data registers = 0.
  - Reset mid-operation discards all in-flight data.
  - in_ready is 1 in the first cycle after rst deasserts.
- Simultaneous events:
  - Output drain and a new accept in the same cycle are legal; S1 refills while S2 takes the old S1.
  - flush has priority over accept and advance.
- Result data registers update only on adv2, never otherwise.

Test Plan:
- Basic sum: re_op1=6, re_op2=3, op2_1=1, addr_cin=1, op=MUL, out_ready=1. Required: result=0xE, out_valid exactly 2 edges after accept.
- Carry across split: re_op1=2^66-1, re_op2=0, op2_1=0, addr_cin=1, op=MULH. Required: product=2^66, result=0x4.
- MULW sign extension: re_op1=0x8000_0000, rest 0, op=MULW. Required: result=0xFFFF_FFFF_8000_0000. Also re_op2=1, op2_1=1 (adds 3) on 0x7FFF_FFFD. Required: 0xFFFF_FFFF_8000_0000.
- Back-pressure: out_ready=0, offer 3 back-to-back MUL ops with re_op1 = 1, 2, 3. Required: 2 accepted, then in_ready=0 and the third is held; result=1 stable. Then raise out_ready. Required: outputs 1, 2, 3 on consecutive cycles.
- Flush: S1 and S2 both valid, out_ready=0, pulse flush with in_valid=1. Required: next cycle out_valid=0, in_ready=1, and no stale result is ever emitted.
- Reset mid-operation: assert rst with 2 in flight. Required: out_valid=0 and result=0 after the edge. A fresh op after release completes with the correct value.
